adc_sample_sequencer: RTL and testbench
=======================================

# adc_sample_sequencer

Per-sample ADC conversion sequencer for the PMU acquisition path. It sits directly downstream of the free-running timebase counter, whose COUNT drives TIMESTAMP. On each accepted sample request it drives the ADC convert/read handshake and captures the conversion result. It then presents the result, tagged with the counter value at request time, on a valid/ready output to the buffering stage.

## Interface
Parameters:
- N, 16, width of TIMESTAMP/OUT_TS; matches the timebase counter width
- DATA_W, 16, ADC result width
- CONV_CYCLES, 4, CNVST high time in CLK cycles (≥1)
- TIMEOUT, 64, max WAIT_BUSY cycles before abort (≥1)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- EN  in  1  enables acceptance of new SAMPLE_TICKs
- SAMPLE_TICK  in  1  one-cycle sample request pulse
- TIMESTAMP  in  N  timebase counter value
- ADC_BUSY  in  1  ADC conversion in progress (synchronous to CLK)
- ADC_DATA  in  DATA_W  ADC parallel result
- CNVST  out  1  convert-start strobe to ADC
- ADC_RD  out  1  read strobe to ADC
- OUT_VALID  out  1  output record valid
- OUT_READY  in  1  downstream accepts record
- OUT_DATA  out  DATA_W  captured sample
- OUT_TS  out  N  timestamp of captured sample
- ACTIVE  out  1  high whenever state ≠ IDLE
- OVERRUN  out  1  sticky; sample dropped because output register was full
- TICK_MISS  out  1  sticky; SAMPLE_TICK arrived while not IDLE
- TIMEOUT_ERR  out  1  sticky; ADC_BUSY never released within TIMEOUT
- CLR_ERR  in  1  synchronous clear of all sticky flags

## Operation
- Reset (nRST low, any time, including mid-conversion):
  - state IDLE;
  - CNVST, ADC_RD, OUT_VALID, ACTIVE, OVERRUN, TICK_MISS and TIMEOUT_ERR all 0;
  - OUT_DATA and OUT_TS 0;
  - internal counters 0;
  - any pending record is discarded.
- FSM states: IDLE, CONVERT, WAIT_BUSY, READ.
- IDLE:
  - SAMPLE_TICK=1 with EN=1 latches TIMESTAMP into the internal timestamp register and moves to CONVERT.
  - SAMPLE_TICK with EN=0 is ignored silently.
- CONVERT: CNVST=1 for exactly CONV_CYCLES cycles, then moves to WAIT_BUSY.
- WAIT_BUSY:
  - ADC_BUSY sampled each cycle; ADC_BUSY=0 moves to READ.
  - Wait counter increments while ADC_BUSY=1.
  - After TIMEOUT cycles with ADC_BUSY=1, set TIMEOUT_ERR, return to IDLE, produce no record.
- READ:
  - ADC_RD=1 for one cycle; ADC_DATA is sampled at the end of that cycle; then return to IDLE.
  - If OUT_VALID=0 or OUT_READY=1 in that cycle, OUT_DATA/OUT_TS load the sample and latched timestamp, and OUT_VALID=1 from the next cycle.
  - Otherwise the sample is dropped, OVERRUN is set, and the held record is unchanged.
- Output handshake:
  - A transfer occurs on a cycle with OUT_VALID=1 and OUT_READY=1.
  - OUT_VALID clears after a transfer unless a new load happens in the same cycle.
  - OUT_DATA/OUT_TS stay stable while OUT_VALID=1 and OUT_READY=0.
- SAMPLE_TICK in CONVERT/WAIT_BUSY/READ sets TICK_MISS; the tick is not queued.
- EN deassertion mid-sequence does not abort; the in-flight conversion completes normally.
- CLR_ERR=1 clears all sticky flags. A set event in the same cycle wins (flag remains 1).
- TIMESTAMP is treated as opaque. Counter wrap-around needs no special handling; OUT_TS simply carries the wrapped value.

## Timing
- Tick accepted at edge ending cycle k:
  - CNVST high in cycles k+1 … k+CONV_CYCLES;
  - WAIT_BUSY from cycle k+CONV_CYCLES+1.
- With ADC_BUSY=0 at the first WAIT cycle:
  - READ (ADC_RD=1) in cycle k+CONV_CYCLES+2;
  - OUT_VALID=1 in cycle k+CONV_CYCLES+3.
  - Minimum tick→valid latency is CONV_CYCLES+3 cycles (7 at defaults).
- Each extra ADC_BUSY=1 cycle in WAIT_BUSY adds one cycle of latency.
- Timeout:
  - abort after TIMEOUT consecutive ADC_BUSY=1 WAIT cycles;
  - TIMEOUT_ERR=1 the following cycle;
  - back in IDLE the following cycle.
- Back-to-back: earliest next tick acceptance is the cycle after READ, giving a minimum sample period of CONV_CYCLES+3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then TIMESTAMP=0x0123, tick in cycle 0, ADC_BUSY=0, ADC_DATA=0xBEEF, OUT_READY=1 → CNVST high cycles 1–4, ADC_RD cycle 6, OUT_VALID cycle 7 with OUT_DATA=0xBEEF, OUT_TS=0x0123.
- ADC_BUSY high for 10 WAIT cycles → OUT_VALID delayed by 10 cycles. ADC_BUSY held high → TIMEOUT_ERR=1 after 64 WAIT cycles, no OUT_VALID, ACTIVE=0 the next cycle.
- OUT_READY=0, two complete samples (0x1111 then 0x2222) → OUT_DATA stays 0x1111, OVERRUN=1. Then OUT_READY=1 → one transfer of 0x1111, OUT_VALID falls.
- Second tick 2 cycles after the first accepted tick → TICK_MISS=1, exactly one record produced. CLR_ERR pulse → flag 0. CLR_ERR coincident with a new miss → flag stays 1.
- TIMESTAMP=0xFFFF at tick → OUT_TS=0xFFFF. Next tick at TIMESTAMP=0x0002 → OUT_TS=0x0002.
- nRST asserted during CONVERT → CNVST falls immediately (asynchronously) and all outputs return to 0. After release, a new tick produces a normal record.

Source files
------------

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
//
// Per-sample ADC conversion sequencer. A sample request (SAMPLE_TICK with EN)
// latches the timebase value, pulses CNVST for CONV_CYCLES cycles, waits for
// ADC_BUSY to drop (bounded by TIMEOUT cycles), strobes ADC_RD for one cycle
// and captures ADC_DATA into a one-deep output register tagged with the
// latched timestamp.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   EN, SAMPLE_TICK      request acceptance enable and request pulse
//   TIMESTAMP [N]        timebase counter value, latched on acceptance
//   ADC_BUSY, ADC_DATA   ADC status and parallel result
//   CNVST, ADC_RD        convert-start and read strobes to the ADC
//   OUT_VALID/OUT_READY  output record handshake
//   OUT_DATA, OUT_TS     captured sample and its timestamp
//   ACTIVE               high whenever the FSM is not in IDLE
//   OVERRUN, TICK_MISS, TIMEOUT_ERR  sticky error flags
//   CLR_ERR              synchronous clear of the sticky flags
//
// All outputs are registered. The FSM state is held in 'state' (type
// state_t) so it can be observed hierarchically.

module adc_sample_sequencer #(
  parameter int N           = 16,
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              EN,
  input  logic              SAMPLE_TICK,
  input  logic [N-1:0]      TIMESTAMP,
  input  logic              ADC_BUSY,
  input  logic [DATA_W-1:0] ADC_DATA,
  output logic              CNVST,
  output logic              ADC_RD,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [N-1:0]      OUT_TS,
  output logic              ACTIVE,
  output logic              OVERRUN,
  output logic              TICK_MISS,
  output logic              TIMEOUT_ERR,
  input  logic              CLR_ERR
);

  localparam int CNT_MAX = (CONV_CYCLES > TIMEOUT) ? CONV_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    WAIT_BUSY = 2'd2,
    READ      = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;     // CONVERT length counter, then WAIT_BUSY counter
  logic [N-1:0]     ts_q;    // timestamp latched at request acceptance

  // Output handshake: a record transfers on any cycle with OUT_VALID=1 and
  // OUT_READY=1. OUT_DATA/OUT_TS only change on a load, and a load is only
  // allowed when the register is empty or being drained in the same cycle,
  // so the record is stable while OUT_VALID=1 and OUT_READY=0.
  logic load;
  logic miss_set;
  logic overrun_set;
  logic timeout_set;

  always_comb begin
    load        = (state == READ) && (!OUT_VALID || OUT_READY);
    overrun_set = (state == READ) && OUT_VALID && !OUT_READY;
    miss_set    = SAMPLE_TICK && (state != IDLE);
    timeout_set = (state == WAIT_BUSY) && ADC_BUSY && (cnt == WAIT_LAST);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      ts_q        <= '0;
      CNVST       <= 1'b0;
      ADC_RD      <= 1'b0;
      ACTIVE      <= 1'b0;
      OUT_VALID   <= 1'b0;
      OUT_DATA    <= '0;
      OUT_TS      <= '0;
      OVERRUN     <= 1'b0;
      TICK_MISS   <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (SAMPLE_TICK && EN) begin
            ts_q   <= TIMESTAMP;
            cnt    <= '0;
            CNVST  <= 1'b1;
            ACTIVE <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt == CONV_LAST) begin
            cnt   <= '0;
            CNVST <= 1'b0;
            state <= WAIT_BUSY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!ADC_BUSY) begin
            cnt    <= '0;
            ADC_RD <= 1'b1;
            state  <= READ;
          end else if (cnt == WAIT_LAST) begin
            // Abort without producing a record.
            cnt    <= '0;
            ACTIVE <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          ADC_RD <= 1'b0;
          ACTIVE <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          cnt    <= '0;
          CNVST  <= 1'b0;
          ADC_RD <= 1'b0;
          ACTIVE <= 1'b0;
          state  <= IDLE;
        end
      endcase

      if (load) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= ADC_DATA;
        OUT_TS    <= ts_q;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      // A set event in the same cycle as CLR_ERR wins.
      OVERRUN     <= overrun_set | (OVERRUN     & ~CLR_ERR);
      TICK_MISS   <= miss_set    | (TICK_MISS   & ~CLR_ERR);
      TIMEOUT_ERR <= timeout_set | (TIMEOUT_ERR & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer
//
// Self-checking bench for adc_sample_sequencer at default parameters:
// table of single-sample scenarios, hand-written multi-cycle sequences
// (overrun, tick miss / error clear, reset mid-conversion) and a randomized
// run against a timeline-based reference model.

module tb_adc_sample_sequencer;

  localparam int C  = 4;   // CONV_CYCLES
  localparam int TO = 64;  // TIMEOUT

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        n_rst;
  logic        en;
  logic        sample_tick;
  logic [15:0] timestamp;
  logic        adc_busy;
  logic [15:0] adc_data;
  logic        cnvst;
  logic        adc_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_ts;
  logic        active;
  logic        overrun;
  logic        tick_miss;
  logic        timeout_err;
  logic        clr_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_sample_sequencer #(
    .N(16), .DATA_W(16), .CONV_CYCLES(C), .TIMEOUT(TO)
  ) dut (
    .CLK(clk),
    .nRST(n_rst),
    .EN(en),
    .SAMPLE_TICK(sample_tick),
    .TIMESTAMP(timestamp),
    .ADC_BUSY(adc_busy),
    .ADC_DATA(adc_data),
    .CNVST(cnvst),
    .ADC_RD(adc_rd),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT_DATA(out_data),
    .OUT_TS(out_ts),
    .ACTIVE(active),
    .OVERRUN(overrun),
    .TICK_MISS(tick_miss),
    .TIMEOUT_ERR(timeout_err),
    .CLR_ERR(clr_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // expected records (data) from the table run

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs set afterwards belong
  // to the new cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en          = 1'b1;
    sample_tick = 1'b0;
    timestamp   = 16'h0;
    adc_busy    = 1'b0;
    adc_data    = 16'h0;
    out_ready   = 1'b1;
    clr_err     = 1'b0;
  endtask

  task automatic pulse_clr();
    cyc(); clr_err = 1'b1;
    cyc(); clr_err = 1'b0;
  endtask

  // Tick at cycle 0 with ADC_BUSY low; returns positioned in cycle 7,
  // the first cycle OUT_VALID may be high.
  task automatic run_sample(input logic [15:0] ts, input logic [15:0] data);
    cyc();
    sample_tick = 1'b1;
    en          = 1'b1;
    timestamp   = ts;
    adc_data    = data;
    adc_busy    = 1'b0;
    repeat (C + 3) begin
      cyc();
      sample_tick = 1'b0;
    end
  endtask

  // ---------------- table of single-sample scenarios ----------------
  typedef struct {
    logic        en;
    logic [15:0] ts;
    logic [15:0] data;
    int          busy_len;   // WAIT cycles with ADC_BUSY high
    int          rd_cyc;     // cycle with ADC_RD high (-1 none)
    int          valid_cyc;  // cycle with OUT_VALID high (-1 none)
    int          idle_cyc;   // first cycle back in IDLE
    logic        to;         // TIMEOUT_ERR expected
  } vec_t;

  vec_t vecs[7];

  // ---------------- reference model state (random phase) ----------------
  int          m_k, m_rd, m_to, m_idle_from, m_blen, r;
  logic        m_idle;
  logic        ev, eov, etm, eto;
  logic [15:0] ed, ets, txn_ts;
  int          records;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0123, 16'hBEEF,  0,  6,  7,  7, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h5A5A,  0,  6,  7,  7, 1'b0};
    vecs[2] = '{1'b1, 16'h0002, 16'h0001,  0,  6,  7,  7, 1'b0};
    vecs[3] = '{1'b1, 16'h4000, 16'h1234, 10, 16, 17, 17, 1'b0};
    vecs[4] = '{1'b1, 16'h0F0F, 16'hC0DE, 63, 69, 70, 70, 1'b0};
    vecs[5] = '{1'b1, 16'h7777, 16'hAAAA, 64, -1, -1, 69, 1'b1};
    vecs[6] = '{1'b0, 16'h5555, 16'h6666,  0, -1, -1,  1, 1'b0};

    idle_inputs();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cnvst",  32'(cnvst),       32'd0);
    check("rst_adc_rd", 32'(adc_rd),      32'd0);
    check("rst_valid",  32'(out_valid),   32'd0);
    check("rst_active", 32'(active),      32'd0);
    check("rst_data",   32'(out_data),    32'd0);
    check("rst_ts",     32'(out_ts),      32'd0);
    check("rst_flags",  32'({overrun, tick_miss, timeout_err}), 32'd0);
    cyc();
    n_rst = 1'b1;
    cyc();

    // ---- table-driven scenarios ----
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].valid_cyc >= 0) exp_q.push_back(vecs[i].data);
      for (int c = 0; c < 75; c++) begin
        cyc();
        sample_tick = (c == 0);
        en          = vecs[i].en;
        out_ready   = 1'b1;
        timestamp   = (c == 0) ? vecs[i].ts : 16'($urandom);
        adc_data    = (c == vecs[i].rd_cyc) ? vecs[i].data : 16'($urandom);
        adc_busy    = (c >= 1) && (c <= C + vecs[i].busy_len);
        @(negedge clk);
        check("tbl_cnvst",  32'(cnvst),  32'(vecs[i].en && c >= 1 && c <= C));
        check("tbl_adc_rd", 32'(adc_rd), 32'(c == vecs[i].rd_cyc));
        check("tbl_valid",  32'(out_valid), 32'(c == vecs[i].valid_cyc));
        check("tbl_active", 32'(active), 32'(c >= 1 && c < vecs[i].idle_cyc));
        check("tbl_timeout", 32'(timeout_err), 32'(vecs[i].to && c >= vecs[i].idle_cyc));
        if (out_valid) begin
          check("tbl_ts", 32'(out_ts), 32'(vecs[i].ts));
          if (exp_q.size() == 0) check("tbl_extra_record", 32'(out_data), 32'hFFFF_FFFF);
          else check("tbl_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      en = 1'b1;
      pulse_clr();
    end
    check("tbl_records_left", 32'(exp_q.size()), 32'd0);

    // ---- overrun: two samples with OUT_READY low ----
    idle_inputs();
    out_ready = 1'b0;
    run_sample(16'h0A00, 16'h1111);
    @(negedge clk);
    check("ovr_first_valid", 32'(out_valid), 32'd1);
    check("ovr_first_data",  32'(out_data),  32'h1111);
    check("ovr_flag_clear",  32'(overrun),   32'd0);
    run_sample(16'h0B00, 16'h2222);
    @(negedge clk);
    check("ovr_hold_data", 32'(out_data), 32'h1111);
    check("ovr_hold_ts",   32'(out_ts),   32'h0A00);
    check("ovr_flag",      32'(overrun),  32'd1);
    check("ovr_valid",     32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    check("ovr_xfer_valid", 32'(out_valid), 32'd1);
    check("ovr_xfer_data",  32'(out_data),  32'h1111);
    cyc();
    @(negedge clk);
    check("ovr_valid_fall", 32'(out_valid), 32'd0);
    check("ovr_sticky",     32'(overrun),   32'd1);

    // ---- tick miss, clear, clear coincident with new miss ----
    pulse_clr();
    cyc(); sample_tick = 1'b1; timestamp = 16'h0C00; adc_data = 16'h3333;  // cycle 0
    cyc(); sample_tick = 1'b0;                                              // cycle 1
    cyc(); sample_tick = 1'b1;                                              // cycle 2
    cyc(); sample_tick = 1'b0;                                              // cycle 3
    @(negedge clk);
    check("miss_set", 32'(tick_miss), 32'd1);
    check("ovr_cleared", 32'(overrun), 32'd0);
    sample_tick = 1'b1;
    clr_err     = 1'b1;
    records     = 0;
    for (int c = 4; c < 21; c++) begin
      cyc();
      sample_tick = 1'b0;
      clr_err     = 1'b0;
      @(negedge clk);
      if (c == 4) check("miss_set_wins", 32'(tick_miss), 32'd1);
      if (out_valid) begin
        records++;
        check("miss_rec_data", 32'(out_data), 32'h3333);
        check("miss_rec_ts",   32'(out_ts),   32'h0C00);
      end
    end
    check("miss_one_record", 32'(records), 32'd1);
    pulse_clr();
    @(negedge clk);
    check("miss_cleared", 32'(tick_miss), 32'd0);

    // ---- reset during CONVERT ----
    cyc(); sample_tick = 1'b1; timestamp = 16'h0D00; adc_data = 16'h4444;
    cyc(); sample_tick = 1'b0;
    cyc();
    @(negedge clk);
    check("rstc_cnvst_before", 32'(cnvst), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("rstc_cnvst",  32'(cnvst),     32'd0);
    check("rstc_active", 32'(active),    32'd0);
    check("rstc_valid",  32'(out_valid), 32'd0);
    check("rstc_data",   32'(out_data),  32'd0);
    check("rstc_ts",     32'(out_ts),    32'd0);
    cyc();
    n_rst = 1'b1;
    run_sample(16'h0E00, 16'h7E57);
    @(negedge clk);
    check("rstc_after_valid", 32'(out_valid), 32'd1);
    check("rstc_after_data",  32'(out_data),  32'h7E57);
    check("rstc_after_ts",    32'(out_ts),    32'h0E00);

    // ---- randomized run against the timeline model ----
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    m_k = -1000; m_rd = -1; m_to = -1; m_idle_from = 0; m_blen = 0;
    ev = 1'b0; eov = 1'b0; etm = 1'b0; eto = 1'b0;
    ed = 16'h0; ets = 16'h0; txn_ts = 16'h0;
    for (int t = 0; t < 3000; t++) begin
      cyc();
      sample_tick = ($urandom_range(0, 5) == 0);
      en          = ($urandom_range(0, 9) != 0);
      timestamp   = 16'($urandom);
      adc_data    = 16'($urandom);
      out_ready   = ($urandom_range(0, 2) != 0);
      clr_err     = ($urandom_range(0, 39) == 0);
      adc_busy    = (t >= m_k + 1) && (t <= m_k + C + m_blen);
      @(negedge clk);
      check("rnd_cnvst",   32'(cnvst),  32'(t >= m_k + 1 && t <= m_k + C));
      check("rnd_adc_rd",  32'(adc_rd), 32'(t == m_rd));
      check("rnd_active",  32'(active), 32'(t < m_idle_from));
      check("rnd_valid",   32'(out_valid), 32'(ev));
      check("rnd_data",    32'(out_data),  32'(ed));
      check("rnd_ts",      32'(out_ts),    32'(ets));
      check("rnd_overrun", 32'(overrun),   32'(eov));
      check("rnd_miss",    32'(tick_miss), 32'(etm));
      check("rnd_timeout", 32'(timeout_err), 32'(eto));

      // model: advance to cycle t+1
      m_idle = (t >= m_idle_from);
      eov = ((t == m_rd) && ev && !out_ready) | (eov & ~clr_err);
      etm = (sample_tick && !m_idle)          | (etm & ~clr_err);
      eto = (t == m_to)                       | (eto & ~clr_err);
      if ((t == m_rd) && (!ev || out_ready)) begin
        ev  = 1'b1;
        ed  = adc_data;
        ets = txn_ts;
      end else if (ev && out_ready) begin
        ev = 1'b0;
      end
      if (sample_tick && en && m_idle) begin
        m_k    = t;
        txn_ts = timestamp;
        r      = int'($urandom_range(0, 19));
        m_blen = (r == 0) ? TO : (r == 1) ? TO - 1 : int'($urandom_range(0, 4));
        if (m_blen >= TO) begin
          m_to        = m_k + C + TO;
          m_rd        = -1;
          m_idle_from = m_to + 1;
        end else begin
          m_rd        = m_k + C + 2 + m_blen;
          m_to        = -1;
          m_idle_from = m_rd + 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
